instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter DATA_W, default 20, instruction/data word width.
REQ-002 Parameter ADDR_W, default 5, instruction memory address width (32 words).
REQ-003 Parameter TIMEOUT_CYC, default 15, fetch watchdog limit in cycles (used only under SEQ_TIMEOUT_EN).
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  one-cycle pulse, leaves IDLE.
REQ-008 mem_req  out  1  fetch request to instruction memory.
REQ-009 mem_addr  out  ADDR_W  fetch address, equals pc.
REQ-010 mem_ack  in  1  memory returns mem_rdata this cycle.
REQ-011 mem_rdata  in  DATA_W  fetched instruction word.
REQ-012 pc_load  in  1  branch taken, sampled in EXEC only.
REQ-013 pc_target  in  ADDR_W  branch destination.
REQ-014 instr  out  DATA_W  latched instruction driven to decoder.
REQ-015 decode_en, exec_en, wb_en  out  1 each  stage strobes; wb_en gates the register-file write enables.
REQ-016 pc  out  ADDR_W  program counter.
REQ-017 busy  out  1  high in FETCH/DECODE/EXEC/WB.
REQ-018 halted  out  1  high in HALT.
REQ-019 fault  out  1  fetch timeout occurred (sticky).

Function
REQ-020 States: IDLE, FETCH, DECODE, EXEC, WB, HALT; outputs mem_req, decode_en, exec_en, wb_en, busy, halted SHALL be decoded from state only.
REQ-021 IDLE -> FETCH on start; start outside IDLE SHALL be ignored.
REQ-022 FETCH: mem_req=1 every cycle until mem_ack; on mem_ack latch instr<=mem_rdata, pc<=pc+1 modulo 2^ADDR_W (31 wraps to 0), go DECODE.
REQ-023 mem_ack outside FETCH SHALL be ignored; instr holds its value outside FETCH.
REQ-024 DECODE lasts 1 cycle; if instr[DATA_W-1:DATA_W-5]==OP_HALT (5'h1F) go HALT, else EXEC.
REQ-025 EXEC lasts 1 cycle; if pc_load=1 then pc<=pc_target (overrides the increment); pc_load in any other state SHALL be ignored.
REQ-026 WB lasts 1 cycle with wb_en=1, then FETCH.
REQ-027 Minimum instruction latency SHALL be 4 cycles (ack in first FETCH cycle); each wait cycle adds 1.
REQ-028 HALT is terminal; exits only by rst; start ignored.

Reset
REQ-029 On rst: state=IDLE, pc=0, instr=0, fault=0; all strobes, mem_req, busy, halted low on the first cycle after the reset edge.
REQ-030 Reset mid-FETCH SHALL abandon the request; a mem_ack arriving the same cycle as rst SHALL not update instr or pc.

Configuration
REQ-031 Macro SEQ_TIMEOUT_EN: when defined, a counter SHALL count consecutive FETCH cycles without mem_ack; when it reaches TIMEOUT_CYC, go HALT and set fault=1; counter clears on mem_ack or leaving FETCH.
REQ-032 Without SEQ_TIMEOUT_EN, FETCH waits indefinitely and fault SHALL be tied to 0.

Structure
REQ-033 Shared package cpu_pkg SHALL hold DATA_W, ADDR_W, opcode field position, OP_HALT and the sequencer state enum.
REQ-034 The watchdog SHALL be sub-module fetch_watchdog, instantiated only under SEQ_TIMEOUT_EN; everything else is flat.

Verification
REQ-035 Reset, start, mem_ack same cycle as mem_req, word 20'h01234 at pc 0 -> instr=20'h01234, strobes one cycle each, next mem_req 4 cycles after first, pc=1.
REQ-036 mem_ack delayed 3 cycles -> mem_req held 4 cycles, mem_addr stable, instruction takes 7 cycles.
REQ-037 pc_load=1, pc_target=5'd9 in EXEC -> next mem_addr=9; same pulse in DECODE -> no effect, pc unchanged.
REQ-038 pc=31, fetch completes -> pc=0; fetch of 20'hF8000 -> HALT, halted=1, start ignored, wb_en never asserted.
REQ-039 rst asserted in FETCH with mem_ack high -> next cycle state IDLE, pc=0, instr=0, mem_req=0.
REQ-040 With SEQ_TIMEOUT_EN, mem_ack never asserted -> HALT and fault=1 after 15 FETCH cycles; without macro, mem_req stays high and fault=0 after 100 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: word/address widths,
// opcode field layout, the halt opcode and the sequencer state encoding.
package cpu_pkg;

  localparam int unsigned DATA_W = 20;
  localparam int unsigned ADDR_W = 5;

  // Opcode occupies the top OPC_W bits of the instruction word.
  localparam int unsigned OPC_W = 5;
  localparam logic [OPC_W-1:0] OP_HALT = 5'h1F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } seq_state_e;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive FETCH cycles without an acknowledge and flags expiry
// on the cycle that reaches TIMEOUT_CYC. Used only when SEQ_TIMEOUT_EN is defined.
module fetch_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ack,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !active || ack) cnt <= '0;
    else                       cnt <= cnt + CNT_W'(1);
  end

  // cnt holds the number of earlier waiting cycles, so this cycle is the TIMEOUT_CYC-th.
  assign expire = active && !ack && (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/exec/writeback instruction sequencer.
// Optional fetch watchdog enabled by defining SEQ_TIMEOUT_EN.
module instr_sequencer #(
  parameter int unsigned DATA_W      = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W      = cpu_pkg::ADDR_W,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic [DATA_W-1:0] instr,
  output logic              decode_en,
  output logic              exec_en,
  output logic              wb_en,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  import cpu_pkg::*;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("instr_sequencer: TIMEOUT_CYC must be at least 1");
  end

  seq_state_e state, state_next;
  logic       timeout;

`ifdef SEQ_TIMEOUT_EN
  logic fault_q;

  fetch_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_fetch_watchdog (
    .clk   (clk),
    .rst   (rst),
    .active(state == S_FETCH),
    .ack   (mem_ack),
    .expire(timeout)
  );

  always_ff @(posedge clk) begin
    if (rst)          fault_q <= 1'b0;
    else if (timeout) fault_q <= 1'b1;
  end

  assign fault = fault_q;
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      instr <= '0;
    end else begin
      state <= state_next;
      if (state == S_FETCH && mem_ack) begin
        instr <= mem_rdata;
        pc    <= pc + ADDR_W'(1);
      end
      if (state == S_EXEC && pc_load) pc <= pc_target;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH: begin
        if (mem_ack)      state_next = S_DECODE;
        else if (timeout) state_next = S_HALT;
      end
      S_DECODE: state_next = (instr[DATA_W-1 -: OPC_W] == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC:   state_next = S_WB;
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_IDLE;
    endcase
  end

  assign mem_req   = (state == S_FETCH);
  assign mem_addr  = pc;
  assign decode_en = (state == S_DECODE);
  assign exec_en   = (state == S_EXEC);
  assign wb_en     = (state == S_WB);
  assign busy      = (state == S_FETCH) || (state == S_DECODE) ||
                     (state == S_EXEC)  || (state == S_WB);
  assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer; covers both builds
// (with and without SEQ_TIMEOUT_EN).
module tb_instr_sequencer;

  localparam int unsigned DW = 20;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          pc_load = 1'b0;
  logic [AW-1:0] pc_target = '0;
  logic [DW-1:0] instr;
  logic          decode_en, exec_en, wb_en;
  logic [AW-1:0] pc;
  logic          busy, halted, fault;

  int unsigned total = 0;
  int unsigned bad   = 0;

  instr_sequencer #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .TIMEOUT_CYC(15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .pc_load  (pc_load),
    .pc_target(pc_target),
    .instr    (instr),
    .decode_en(decode_en),
    .exec_en  (exec_en),
    .wb_en    (wb_en),
    .pc       (pc),
    .busy     (busy),
    .halted   (halted),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // strobe vector {mem_req, decode_en, exec_en, wb_en, busy, halted}
  function automatic logic [31:0] strobes();
    return {26'd0, mem_req, decode_en, exec_en, wb_en, busy, halted};
  endfunction

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_strobes", strobes(), 32'b000000);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_fault", 32'(fault), 0);

    // Zero-wait fetch of 20'h01234 at pc 0
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("f0_strobes", strobes(), 32'b100010);
    chk("f0_addr", 32'(mem_addr), 0);
    mem_ack = 1'b1;
    mem_rdata = 20'h01234;
    tick();
    mem_ack = 1'b0;
    chk("d0_strobes", strobes(), 32'b010010);
    chk("d0_instr", 32'(instr), 32'h01234);
    chk("d0_pc", 32'(pc), 1);
    tick();
    chk("e0_strobes", strobes(), 32'b001010);
    tick();
    chk("w0_strobes", strobes(), 32'b000110);
    tick();
    chk("f1_strobes", strobes(), 32'b100010);
    chk("f1_addr", 32'(mem_addr), 1);

    // Ack delayed by 3 cycles: request held 4 cycles at a stable address
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_req", 32'(mem_req), 1);
      chk("wait_addr", 32'(mem_addr), 1);
    end
    mem_ack = 1'b1;
    mem_rdata = 20'h00ABC;
    tick();
    chk("d1_strobes", strobes(), 32'b010010);
    chk("d1_instr", 32'(instr), 32'h00ABC);
    chk("d1_pc", 32'(pc), 2);

    // Ack and pc_load during DECODE must both be ignored
    mem_ack = 1'b1;
    mem_rdata = 20'h55555;
    pc_load = 1'b1;
    pc_target = 5'd9;
    tick();
    mem_ack = 1'b0;
    chk("e1_strobes", strobes(), 32'b001010);
    chk("e1_instr_hold", 32'(instr), 32'h00ABC);
    chk("e1_pc_nodecode_load", 32'(pc), 2);

    // pc_load in EXEC redirects the next fetch
    tick();
    pc_load = 1'b0;
    chk("w1_strobes", strobes(), 32'b000110);
    chk("w1_pc", 32'(pc), 9);
    tick();
    chk("f2_addr", 32'(mem_addr), 9);
    chk("f2_req", 32'(mem_req), 1);

    // Branch to 31, then fetch there to wrap pc to 0
    mem_ack = 1'b1;
    mem_rdata = 20'h00001;
    tick();
    mem_ack = 1'b0;
    chk("d2_pc", 32'(pc), 10);
    tick();
    pc_load = 1'b1;
    pc_target = 5'd31;
    tick();
    pc_load = 1'b0;
    chk("w2_pc", 32'(pc), 31);
    tick();
    chk("f3_addr", 32'(mem_addr), 31);
    mem_ack = 1'b1;
    mem_rdata = 20'h12345;
    tick();
    mem_ack = 1'b0;
    chk("d3_pc_wrap", 32'(pc), 0);
    chk("d3_instr", 32'(instr), 32'h12345);
    tick();
    tick();
    tick();
    chk("f4_addr", 32'(mem_addr), 0);

    // Halt opcode: DECODE goes to HALT, no writeback, start ignored
    mem_ack = 1'b1;
    mem_rdata = 20'hF8000;
    tick();
    mem_ack = 1'b0;
    chk("d4_strobes", strobes(), 32'b010010);
    chk("d4_instr", 32'(instr), 32'hF8000);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_strobes", strobes(), 32'b000001);
    end
    start = 1'b0;
    chk("halt_pc", 32'(pc), 1);

    // Reset mid-FETCH with a concurrent ack
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_strobes", strobes(), 32'b000000);
    start = 1'b1;
    tick();
    start = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 20'h0BEEF;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
    tick();
    chk("f5_addr", 32'(mem_addr), 1);
    chk("f5_instr", 32'(instr), 32'h0BEEF);
    rst = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 20'h77777;
    tick();
    rst = 1'b0;
    mem_ack = 1'b0;
    chk("rst3_strobes", strobes(), 32'b000000);
    chk("rst3_pc", 32'(pc), 0);
    chk("rst3_instr", 32'(instr), 0);
    tick();
    chk("rst3_idle_hold", strobes(), 32'b000000);

    // Memory never acknowledges
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    chk("to_req_c1", 32'(mem_req), 1);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("to_req_wait", 32'(mem_req), 1);
      chk("to_fault_early", 32'(fault), 0);
    end
    tick();
    chk("to_strobes", strobes(), 32'b000001);
    chk("to_fault", 32'(fault), 1);
    tick();
    chk("to_fault_sticky", 32'(fault), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("to_fault_clr", 32'(fault), 0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("nto_req", 32'(mem_req), 1);
      chk("nto_fault", 32'(fault), 0);
    end
    chk("nto_addr", 32'(mem_addr), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
